// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INST   = 32'h0;
    localparam int unsigned BOOT_CNT_W = 4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Saturating event counter: clears on clr, increments on inc, sticks at all-ones.
module fetch_perf_ctr #(
    parameter int unsigned CTR_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CTR_WIDTH-1:0] count
);

    localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};

    logic [CTR_WIDTH-1:0] count_q;
    logic [CTR_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != CTR_MAX)) begin
            count_d = count_q + CTR_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with F/D pipeline latch, boot delay, stall and redirect handling.
// Optional perf counters (stall_count, flush_count) are built when FETCH_PERF_EN is defined.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int unsigned BOOT_CYCLES = 1
`ifdef FETCH_PERF_EN
    ,
    parameter int unsigned CTR_WIDTH   = 32
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    input  logic [31:0]           q_imem,
    output logic [ADDR_WIDTH-1:0] address_imem,
    output logic [31:0]           fd_inst,
    output logic [31:0]           fd_pc,
    output logic                  fd_valid,
    output logic                  flush_dx
`ifdef FETCH_PERF_EN
    ,
    output logic [CTR_WIDTH-1:0]  stall_count,
    output logic [CTR_WIDTH-1:0]  flush_count
`endif
);

    localparam logic [BOOT_CNT_W-1:0] BOOT_LAST = BOOT_CNT_W'(BOOT_CYCLES - 1);

    fetch_state_e          state_q,    state_d;
    logic [BOOT_CNT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic [31:0]           pc_q,       pc_d;
    logic [31:0]           fd_inst_q,  fd_inst_d;
    logic [31:0]           fd_pc_q,    fd_pc_d;
    logic                  fd_valid_q, fd_valid_d;
    logic [31:0]           pc_inc;

    assign pc_inc = pc_q + 32'd1;

    // Next-state and F/D update: redirect beats stall beats advance once running.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;
        fd_inst_d  = fd_inst_q;
        fd_pc_d    = fd_pc_q;
        fd_valid_d = fd_valid_q;
        unique case (state_q)
            BOOT: begin
                boot_cnt_d = boot_cnt_q + BOOT_CNT_W'(1);
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (redirect) begin
                    pc_d       = redirect_pc;
                    fd_inst_d  = NOP_INST;
                    fd_pc_d    = 32'h0;
                    fd_valid_d = 1'b0;
                end else if (!stall) begin
                    pc_d       = pc_inc;
                    fd_inst_d  = q_imem;
                    fd_pc_d    = pc_inc;
                    fd_valid_d = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= BOOT;
            boot_cnt_q <= '0;
            pc_q       <= RESET_PC;
            fd_inst_q  <= NOP_INST;
            fd_pc_q    <= 32'h0;
            fd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
            fd_inst_q  <= fd_inst_d;
            fd_pc_q    <= fd_pc_d;
            fd_valid_q <= fd_valid_d;
        end
    end

    assign address_imem = pc_q[ADDR_WIDTH-1:0];
    assign fd_inst      = fd_inst_q;
    assign fd_pc        = fd_pc_q;
    assign fd_valid     = fd_valid_q;
    assign flush_dx     = redirect & (state_q == RUN) & ~reset;

`ifdef FETCH_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = (state_q == RUN) & stall & ~redirect;
    assign flush_inc = (state_q == RUN) & redirect;

    fetch_perf_ctr #(.CTR_WIDTH(CTR_WIDTH)) u_stall_ctr (
        .clock (clock),
        .clr   (reset),
        .inc   (stall_inc),
        .count (stall_count)
    );

    fetch_perf_ctr #(.CTR_WIDTH(CTR_WIDTH)) u_flush_ctr (
        .clock (clock),
        .clr   (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );
`else
    // Perf counters not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (boot delay 1 and 3) against a behavioural model.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset, stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] q0, q1;
    logic [11:0] a0, a1;
    logic [31:0] i0, i1, p0, p1;
    logic        v0, v1, f0, f1;
`ifdef FETCH_PERF_EN
    logic [31:0] sc0, sc1, fc0, fc1;
`endif

    always #5 clock = ~clock;

    fetch_stage #(.ADDR_WIDTH(12), .RESET_PC(32'h0), .BOOT_CYCLES(1)) dut_b1 (
        .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .q_imem(q0), .address_imem(a0),
        .fd_inst(i0), .fd_pc(p0), .fd_valid(v0), .flush_dx(f0)
`ifdef FETCH_PERF_EN
        , .stall_count(sc0), .flush_count(fc0)
`endif
    );

    fetch_stage #(.ADDR_WIDTH(12), .RESET_PC(32'h0), .BOOT_CYCLES(3)) dut_b3 (
        .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .q_imem(q1), .address_imem(a1),
        .fd_inst(i1), .fd_pc(p1), .fd_valid(v1), .flush_dx(f1)
`ifdef FETCH_PERF_EN
        , .stall_count(sc1), .flush_count(fc1)
`endif
    );

    int          total = 0;
    int          bad   = 0;

    // Reference state per instance: index 0 boots in 1 cycle, index 1 in 3.
    int          boot_cfg [2] = '{1, 3};
    int          m_boot   [2] = '{1, 3};
    logic [31:0] m_pc     [2] = '{32'h0, 32'h0};
    logic [31:0] m_inst   [2] = '{32'h0, 32'h0};
    logic [31:0] m_fdpc   [2] = '{32'h0, 32'h0};
    logic        m_valid  [2] = '{1'b0, 1'b0};
    logic [31:0] m_sc     [2] = '{32'h0, 32'h0};
    logic [31:0] m_fc     [2] = '{32'h0, 32'h0};
    logic        f_pre    [2] = '{1'b0, 1'b0};
    logic [31:0] saved_sc, saved_fc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] imem_word(input logic [31:0] pc);
        return pc << 4;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_edge(input int k, input logic rst, input logic st,
                              input logic rd, input logic [31:0] rpc);
        if (rst) begin
            m_boot[k]  = boot_cfg[k];
            m_pc[k]    = 32'h0;
            m_inst[k]  = 32'h0;
            m_fdpc[k]  = 32'h0;
            m_valid[k] = 1'b0;
            m_sc[k]    = 32'h0;
            m_fc[k]    = 32'h0;
        end else if (m_boot[k] > 0) begin
            m_boot[k] = m_boot[k] - 1;
        end else if (rd) begin
            m_pc[k]    = rpc;
            m_inst[k]  = 32'h0;
            m_fdpc[k]  = 32'h0;
            m_valid[k] = 1'b0;
            m_fc[k]    = sat_inc(m_fc[k]);
        end else if (st) begin
            m_sc[k] = sat_inc(m_sc[k]);
        end else begin
            m_inst[k]  = imem_word(m_pc[k]);
            m_pc[k]    = m_pc[k] + 32'd1;
            m_fdpc[k]  = m_pc[k];
            m_valid[k] = 1'b1;
        end
    endtask

    task automatic check_outputs(input int k);
        string s;
        s = (k == 0) ? "b1" : "b3";
        check({s, "_addr"},  32'((k == 0) ? a0 : a1), 32'(m_pc[k][11:0]));
        check({s, "_inst"},  (k == 0) ? i0 : i1, m_inst[k]);
        check({s, "_fdpc"},  (k == 0) ? p0 : p1, m_fdpc[k]);
        check({s, "_valid"}, 32'((k == 0) ? v0 : v1), 32'(m_valid[k]));
`ifdef FETCH_PERF_EN
        check({s, "_stallcnt"}, (k == 0) ? sc0 : sc1, m_sc[k]);
        check({s, "_flushcnt"}, (k == 0) ? fc0 : fc1, m_fc[k]);
`endif
    endtask

    // One clock: drive inputs, check the combinational flush, clock, then check registered state.
    task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] rpc);
        reset       = rst;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        q0          = imem_word(m_pc[0]);
        q1          = imem_word(m_pc[1]);
        #1;
        f_pre[0] = f0;
        f_pre[1] = f1;
        for (int k = 0; k < 2; k++) begin
            check((k == 0) ? "b1_flush" : "b3_flush", 32'(f_pre[k]),
                  32'(rd && !rst && (m_boot[k] == 0)));
        end
        @(posedge clock);
        for (int k = 0; k < 2; k++) model_edge(k, rst, st, rd, rpc);
        #1;
        for (int k = 0; k < 2; k++) check_outputs(k);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        q0 = 32'h0; q1 = 32'h0;
        @(posedge clock);
        #1;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h55);
        check("rst_valid", 32'(v0), 32'h0);
        check("rst_inst", i0, 32'h0);

        // Straight-line fetch after a one-cycle boot
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("boot_valid", 32'(v0), 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("f1_inst", i0, 32'h00); check("f1_pc", p0, 32'd1); check("f1_valid", 32'(v0), 32'h1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("f2_inst", i0, 32'h10); check("f2_pc", p0, 32'd2);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("f3_inst", i0, 32'h20); check("f3_pc", p0, 32'd3); check("f3_addr", 32'(a0), 32'd3);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("pre_stall_pc", p0, 32'd5);

        // Stall holds PC and F/D
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            check("stall_addr", 32'(a0), 32'd5);
            check("stall_fdpc", p0, 32'd5);
            check("stall_inst", i0, 32'h40);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("resume_fdpc", p0, 32'd6); check("resume_inst", i0, 32'h50);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("pre_redir_addr", 32'(a0), 32'd7);

        // Redirect squashes F/D and retargets PC
        step(1'b0, 1'b0, 1'b1, 32'h40);
        check("redir_flush", 32'(f_pre[0]), 32'h1);
        check("redir_inst", i0, 32'h0); check("redir_valid", 32'(v0), 32'h0);
        check("redir_addr", 32'(a0), 32'h40);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("target_fdpc", p0, 32'h41); check("target_inst", i0, 32'h400);

        // Redirect together with stall: redirect wins
        saved_sc = m_sc[0];
        saved_fc = m_fc[0];
        step(1'b0, 1'b1, 1'b1, 32'h80);
        check("rs_addr", 32'(a0), 32'h80); check("rs_valid", 32'(v0), 32'h0);
`ifdef FETCH_PERF_EN
        check("rs_stallcnt", sc0, saved_sc);
        check("rs_flushcnt", fc0, saved_fc + 32'd1);
`endif

        // PC wrap at the top of the 32-bit space
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        check("wrap_addr", 32'(a0), 32'hFFF);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_fdpc", p0, 32'h0); check("wrap_addr0", 32'(a0), 32'h0);
        check("wrap_inst", i0, 32'hFFFF_FFF0);

        // Reset mid-stall/redirect; three-cycle boot ignores redirect
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h99);
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b0, 1'b1, 32'h123);
            check("b3_boot_flush", 32'(f_pre[1]), 32'h0);
            check("b3_boot_valid", 32'(v1), 32'h0);
            check("b3_boot_addr", 32'(a1), 32'h0);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("b3_first_valid", 32'(v1), 32'h1);
        check("b3_first_fdpc", p1, 32'd1);
        check("b3_first_inst", i1, 32'h0);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1))
                                              : $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
